// File: rtl/mem_addr_arbiter_pkg.sv
// Shared types and constants for the memory address arbiter: FSM states,
// arbitration mode selectors and the grant-index width helper.
package mem_addr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Never returns 0 so index ports stay legal even for degenerate sizes.
  function automatic int grant_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_addr_arbiter_rr_priority_picker.sv
// Combinational winner selection: first set request at or after the pointer
// (round-robin), or lowest set index when the pointer is bypassed (fixed).
module rr_priority_picker
  import mem_addr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int RR_MODE = ARB_RR,
  parameter int GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      idx,
  output logic               found
);

  // Scan NUM_REQ candidates starting at base; the wrap is an explicit
  // subtraction so non-power-of-two requester counts stay in range.
  always_comb begin
    int          base;
    int          cand;
    logic [GW-1:0] cidx;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    base  = (RR_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = base + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = cand[GW-1:0];
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/mem_addr_arbiter.sv
// N-way memory address arbiter: picks a requester, registers its address and
// holds it stable toward memory until the transaction completes.
module mem_addr_arbiter
  import mem_addr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 64,
  parameter int RR_MODE    = ARB_RR,
  localparam int GW        = grant_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic                          o_mem_valid,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [GW-1:0]                 o_grant_id,
  input  logic                          i_mem_ready,
  input  logic                          i_mem_done,
  output logic                          o_busy
);

  arb_state_t          state;
  logic [GW-1:0]       ptr;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [GW-1:0]       pick_idx;
  logic                pick_found;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [GW-1:0]       next_ptr;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .RR_MODE (RR_MODE),
    .GW      (GW)
  ) u_picker (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // One-hot AND-OR mux keeps the address path free of a wide index decoder.
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) pick_addr = pick_addr | i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign next_ptr = (o_grant_id == GW'(NUM_REQ - 1)) ? '0 : o_grant_id + GW'(1);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state       <= IDLE;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_grant_id  <= '0;
      ptr         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            o_mem_addr  <= pick_addr;
            o_grant_id  <= pick_idx;
            o_mem_valid <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            if (i_mem_done) begin
              state <= IDLE;
              if (RR_MODE == ARB_RR) ptr <= next_ptr;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_mem_done) begin
            state <= IDLE;
            if (RR_MODE == ARB_RR) ptr <= next_ptr;
          end
        end
        default: begin
          state       <= IDLE;
          o_mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // The ack must land in the accept cycle itself, so it is decoded from state.
  always_comb begin
    o_req_ack = '0;
    if (state == ADDR && i_mem_ready) o_req_ack[o_grant_id] = 1'b1;
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Randomized bench: a round-robin and a fixed-priority arbiter share stimulus
// and are compared against a transaction-level arbitration model.
module tb_mem_addr_arbiter;

  localparam int N  = 3;
  localparam int AW = 64;

  logic            clk = 1'b0;
  logic            arstn;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic            mem_ready;
  logic            mem_done;

  logic [N-1:0]  ack_rr, ack_fx;
  logic          valid_rr, valid_fx;
  logic [AW-1:0] addr_rr, addr_fx;
  logic [1:0]    gid_rr, gid_fx;
  logic          busy_rr, busy_fx;

  int compared   = 0;
  int mismatched = 0;

  int            ptr_rr;
  int            win_rr, win_fx;
  logic [AW-1:0] last_rr, last_fx;
  logic [AW-1:0] addrs [N];

  always #5 clk = ~clk;

  mem_addr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .RR_MODE(1)) dut_rr (
    .clk(clk), .arstn(arstn), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ack(ack_rr), .o_mem_valid(valid_rr), .o_mem_addr(addr_rr),
    .o_grant_id(gid_rr), .i_mem_ready(mem_ready), .i_mem_done(mem_done),
    .o_busy(busy_rr)
  );

  mem_addr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .RR_MODE(0)) dut_fx (
    .clk(clk), .arstn(arstn), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ack(ack_fx), .o_mem_valid(valid_fx), .o_mem_addr(addr_fx),
    .o_grant_id(gid_fx), .i_mem_ready(mem_ready), .i_mem_done(mem_done),
    .o_busy(busy_fx)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // First set request scanning from start, wrapping modulo N.
  function automatic int pickWinner(input logic [N-1:0] mask, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic driveAddrs();
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addrs[i];
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy_rr"},  64'(busy_rr),  64'd0);
    checkOutput({tag, " busy_fx"},  64'(busy_fx),  64'd0);
    checkOutput({tag, " valid_rr"}, 64'(valid_rr), 64'd0);
    checkOutput({tag, " valid_fx"}, 64'(valid_fx), 64'd0);
    checkOutput({tag, " addr_rr"},  addr_rr,       last_rr);
    checkOutput({tag, " addr_fx"},  addr_fx,       last_fx);
    checkOutput({tag, " ack_rr"},   64'(ack_rr),   64'd0);
    checkOutput({tag, " ack_fx"},   64'(ack_fx),   64'd0);
  endtask

  // Entered at a falling edge with both arbiters idle; leaves them idle again.
  task automatic applyStimulus(input logic [N-1:0] mask, input int ready_delay,
                               input int done_delay, input bit corrupt);
    req_valid = mask;
    driveAddrs();
    mem_ready = 1'($urandom_range(0, 1));
    mem_done  = 1'($urandom_range(0, 1));
    #1 checkIdle("pre-grant");
    win_rr = pickWinner(mask, ptr_rr);
    win_fx = pickWinner(mask, 0);
    @(negedge clk);
    checkOutput("grant valid_rr", 64'(valid_rr), 64'd1);
    checkOutput("grant valid_fx", 64'(valid_fx), 64'd1);
    checkOutput("grant busy_rr",  64'(busy_rr),  64'd1);
    checkOutput("grant id_rr",    64'(gid_rr),   64'(win_rr));
    checkOutput("grant id_fx",    64'(gid_fx),   64'(win_fx));
    checkOutput("grant addr_rr",  addr_rr,       addrs[win_rr]);
    checkOutput("grant addr_fx",  addr_fx,       addrs[win_fx]);
    last_rr   = addrs[win_rr];
    last_fx   = addrs[win_fx];
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    if (corrupt) begin
      req_addr[win_rr*AW +: AW] = 64'hDEAD;
      req_addr[win_fx*AW +: AW] = 64'hDEAD;
      req_valid[win_rr] = 1'b0;
      req_valid[win_fx] = 1'b0;
    end
    for (int i = 0; i < ready_delay; i++) begin
      #1 checkOutput("hold ack_rr", 64'(ack_rr), 64'd0);
      @(negedge clk);
      checkOutput("hold valid_rr", 64'(valid_rr), 64'd1);
      checkOutput("hold addr_rr",  addr_rr,       last_rr);
      checkOutput("hold addr_fx",  addr_fx,       last_fx);
      checkOutput("hold id_fx",    64'(gid_fx),   64'(win_fx));
    end
    mem_ready = 1'b1;
    mem_done  = (done_delay == 0);
    #1;
    checkOutput("accept ack_rr", 64'(ack_rr), 64'(3'b001 << win_rr));
    checkOutput("accept ack_fx", 64'(ack_fx), 64'(3'b001 << win_fx));
    @(negedge clk);
    mem_done = 1'b0;
    if (done_delay > 0) begin
      for (int i = 0; i < done_delay; i++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        checkOutput("wait valid_rr", 64'(valid_rr), 64'd0);
        checkOutput("wait busy_rr",  64'(busy_rr),  64'd1);
        checkOutput("wait ack_rr",   64'(ack_rr),   64'd0);
        checkOutput("wait ack_fx",   64'(ack_fx),   64'd0);
        if (i == done_delay - 1) mem_done = 1'b1;
        @(negedge clk);
      end
      mem_done = 1'b0;
    end
    mem_ready = 1'b0;
    ptr_rr = (win_rr + 1) % N;
  endtask

  task automatic idleCycles(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkIdle("idle");
    end
    mem_ready = 1'b0;
    mem_done  = 1'b0;
  endtask

  initial begin
    arstn     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    mem_ready = 1'b0;
    mem_done  = 1'b0;
    ptr_rr    = 0;
    last_rr   = '0;
    last_fx   = '0;
    for (int i = 0; i < N; i++) addrs[i] = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    arstn = 1'b1;
    idleCycles(10);

    // Reset during ADDR with ready high: immediate abort, no ack.
    addrs[2] = 64'h2222;
    driveAddrs();
    req_valid = 3'b100;
    @(negedge clk);
    checkOutput("pre-abort valid", 64'(valid_rr), 64'd1);
    mem_ready = 1'b1;
    arstn     = 1'b0;
    #1;
    checkOutput("abort valid_rr", 64'(valid_rr), 64'd0);
    checkOutput("abort addr_rr",  addr_rr,       64'd0);
    checkOutput("abort id_rr",    64'(gid_rr),   64'd0);
    checkOutput("abort busy_rr",  64'(busy_rr),  64'd0);
    checkOutput("abort ack_rr",   64'(ack_rr),   64'd0);
    checkOutput("abort ack_fx",   64'(ack_fx),   64'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = '0;
    arstn     = 1'b1;
    ptr_rr    = 0;
    @(negedge clk);

    // Rotation with single-cycle memory and all requesters valid.
    addrs[0] = 64'hA0; addrs[1] = 64'hB0; addrs[2] = 64'hC0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(3'b111, 0, 0, 1'b0);
      checkOutput("rotation order", 64'(win_rr), 64'(t % N));
    end

    // Lone request on requester 1, slow memory.
    addrs[1] = 64'h1000;
    applyStimulus(3'b010, 2, 3, 1'b0);
    checkOutput("single grant id", 64'(win_rr), 64'd1);

    // Pointer now 2; only requester 0 asks, so the scan must wrap.
    applyStimulus(3'b001, 0, 0, 1'b0);
    checkOutput("wrap grant id", 64'(win_rr), 64'd0);
    idleCycles(3);

    // Fixed priority with requester 0 dropped, then address corruption.
    applyStimulus(3'b110, 1, 1, 1'b0);
    addrs[0] = 64'h5555; addrs[1] = 64'h6666; addrs[2] = 64'h7777;
    applyStimulus(3'b111, 2, 2, 1'b1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) addrs[i] = {$urandom, $urandom};
      applyStimulus(3'($urandom_range(1, 7)), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_addr_arbiter.md
Name: mem_addr_arbiter

Overview:
Parametrised N-way memory address selector/arbiter for the multicycle core.
- Chooses one of NUM_REQ requesters (e.g. PC fetch, load/store address, cache write-back) and registers its address toward memory.
- Holds that address stable across the whole memory transaction.
- Supports fixed-priority or round-robin arbitration, with a valid/ready handshake on both sides.

Parameters:
- NUM_REQ, 3, number of requesters (>=2).
- ADDR_WIDTH, 64, address width in bits.
- RR_MODE, 1, 0 = fixed priority (index 0 highest); 1 = round-robin.

Ports:
- clk  input  1  system clock, rising edge.
- arstn  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester request.
- i_req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_req_ack  output  NUM_REQ  one-cycle pulse to requester k when memory accepts its address.
- o_mem_valid  output  1  address valid toward memory.
- o_mem_addr  output  ADDR_WIDTH  registered selected address.
- o_grant_id  output  GW  index of current grantee; GW = $clog2(NUM_REQ).
- i_mem_ready  input  1  memory accepts address (sampled only while o_mem_valid=1).
- i_mem_done  input  1  memory transaction complete.
- o_busy  output  1  arbiter is not in IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset arstn is asynchronous, active-low.
- Reset values: state=IDLE, o_mem_valid=0, o_mem_addr=0, o_grant_id=0, o_req_ack=0, o_busy=0, rr pointer=0. Reset asserted mid-transaction aborts immediately to these values; no ack is issued.
- FSM states: IDLE, ADDR, WAIT.
- IDLE:
  - If any i_req_valid is set, select a winner.
  - Fixed mode: lowest set index wins.
  - RR mode: first set index at or after the pointer, wrapping modulo NUM_REQ.
  - Next edge: register the winner's address into o_mem_addr, set o_grant_id, o_mem_valid=1, go to ADDR.
  - Latency: request to o_mem_valid is 1 cycle.
  - If no request, stay in IDLE.
- ADDR:
  - o_mem_valid=1. o_mem_addr and o_grant_id are frozen, even if requester inputs change.
  - On i_mem_ready=1: pulse o_req_ack[o_grant_id] for exactly one cycle (combinational with the accept cycle), drop o_mem_valid next edge, go to WAIT.
  - If i_mem_ready=1 and i_mem_done=1 in the same cycle: ack as above, go directly to IDLE (single-cycle memory).
- WAIT:
  - o_mem_valid=0.
  - On i_mem_done=1: go to IDLE.
  - RR mode: pointer = (o_grant_id+1) mod NUM_REQ, with explicit wrap when NUM_REQ is not a power of 2.
- Pointer update: fixed mode never changes the pointer.
- Ignored inputs:
  - i_mem_done outside ADDR/WAIT.
  - i_mem_ready outside ADDR.
- No abort: a grantee deasserting i_req_valid after grant does not cancel the transaction. The registered address is still issued and acked.
- Back-to-back: IDLE is always visited for one cycle between transactions, so re-arbitration happens every transaction.
- Fairness: in RR mode, with all requesters continuously valid, grants rotate 0,1,2,0,…
- o_busy = (state != IDLE).
- o_mem_addr keeps its last value in IDLE; it is not cleared.

Decomposition:
- Shared package: FSM state enum (IDLE, ADDR, WAIT), arbitration mode constants (ARB_FIXED=0, ARB_RR=1), and GW width helper.
- One natural sub-module, rr_priority_picker: combinational, NUM_REQ-bit request vector plus pointer in, one-hot grant plus index out, with a fixed-priority bypass when RR_MODE=0.
- Top module holds the FSM, address register and pointer.

Test Plan:
1. Reset release, no requests: all outputs 0, o_busy=0 for 10 cycles. Then assert arstn=0 during ADDR: outputs return to 0 asynchronously, no o_req_ack pulse.
2. Single request: req 1 valid with addr 0x1000, i_mem_ready asserted 2 cycles after o_mem_valid, i_mem_done 3 cycles later.
   - Required: o_mem_valid rises 1 cycle after the request, o_mem_addr=0x1000, o_grant_id=1.
   - Exactly one o_req_ack[1] pulse; back in IDLE after done.
3. RR fairness: NUM_REQ=3, all valid continuously, addrs 0xA0/0xB0/0xC0, single-cycle ready+done → grant sequence 0,1,2,0,1,2; o_mem_addr 0xA0,0xB0,0xC0 repeating.
4. Fixed priority: RR_MODE=0, all valid → grant is always 0. Drop req 0 → grant 1.
5. Address stability: change i_req_addr[grantee] to 0xDEAD and drop its valid during ADDR → o_mem_addr unchanged, transaction still completes with an ack.
6. Wrap and corners:
   - NUM_REQ=3, pointer=2, requests {0} only → grant 0.
   - Spurious i_mem_done in IDLE → no state change.
